// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline types and constants: fetch FSM states, next-PC select codes,
// bubble instruction and word-alignment helper.
package rv32_pipeline_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_SAVED  = 2'd3
    } pc_sel_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_next_sel.sv
// Combinational next-PC mux: hold / pc+4 (modulo 2^32) / branch target / saved target.
// Redirect addresses are forced word-aligned here.
module pc_next_sel
    import rv32_pipeline_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] saved_target,
    input  pc_sel_t         sel,
    output logic [XLEN-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        unique case (sel)
            PC_KEEP:   next_pc = pc;
            PC_INC:    next_pc = pc + PC_STEP;
            PC_BRANCH: next_pc = align_word(branch_target);
            PC_SAVED:  next_pc = align_word(saved_target);
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem read handshake, holds one
// word while IF/ID is stalled, and squashes fetches overtaken by an EX redirect.
module if_fetch_unit
    import rv32_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        hazard_stall,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_stall
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  held_instr, held_instr_n;
    logic         kill_pending, kill_pending_n;
    logic [31:0]  saved_target, saved_target_n;
    pc_sel_t      pc_sel;
    logic         complete;

    assign complete  = (state == FETCH) && !imem_busywait;
    assign imem_addr = pc;
    assign if_pc     = pc;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .branch_target (branch_target),
        .saved_target  (saved_target),
        .sel           (pc_sel),
        .next_pc       (pc_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            held_instr   <= NOP_INSTR;
            kill_pending <= 1'b0;
            saved_target <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            held_instr   <= held_instr_n;
            kill_pending <= kill_pending_n;
            saved_target <= saved_target_n;
        end
    end

    always_comb begin
        state_n        = state;
        pc_sel         = PC_KEEP;
        held_instr_n   = held_instr;
        kill_pending_n = kill_pending;
        saved_target_n = saved_target;
        unique case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (complete && branch_taken) begin
                    pc_sel         = PC_BRANCH;
                    kill_pending_n = 1'b0;
                end else if (complete && kill_pending) begin
                    pc_sel         = PC_SAVED;
                    kill_pending_n = 1'b0;
                end else if (!complete && branch_taken) begin
                    // Request stays up; the in-flight word is dropped when it lands.
                    kill_pending_n = 1'b1;
                    saved_target_n = align_word(branch_target);
                end else if (complete && hazard_stall) begin
                    held_instr_n = imem_readdata;
                    state_n      = HOLD;
                end else if (complete) begin
                    pc_sel = PC_INC;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_sel  = PC_BRANCH;
                    state_n = FETCH;
                end else if (!hazard_stall) begin
                    pc_sel  = PC_INC;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        imem_read      = 1'b0;
        if_stall       = 1'b0;
        if_instruction = NOP_INSTR;
        unique case (state)
            IDLE: ;
            FETCH: begin
                imem_read = 1'b1;
                if_stall  = imem_busywait;
                if (complete && !kill_pending && !branch_taken)
                    if_instruction = imem_readdata;
            end
            HOLD: begin
                if (!branch_taken)
                    if_instruction = held_instr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; every IF/ID capture is scored against a queue
// of expected (pc, instruction) pairs pushed as the stimulus is driven.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        hazard_stall;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_stall;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } cap_t;
    cap_t sb_q[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .hazard_stall   (hazard_stall),
        .imem_read      (imem_read),
        .imem_addr      (imem_addr),
        .imem_readdata  (imem_readdata),
        .imem_busywait  (imem_busywait),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_stall       (if_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0060_0113;
            32'h0000_0008: return 32'h0070_0193;
            32'h0000_000C: return 32'h0080_0213;
            32'h0000_0010: return 32'h00A0_0513;
            32'h0000_0020: return 32'h0100_0613;
            32'h0000_0030: return 32'h0300_0713;
            32'h0000_0100: return 32'h0200_0693;
            32'h0000_0200: return 32'h0400_0793;
            default:       return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign imem_readdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_cap(input logic [31:0] pc, input logic [31:0] instr);
        sb_q.push_back({pc, instr});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // IF/ID captures whenever its busy_wait (if_stall | hazard_stall) is low.
    always @(negedge clk) begin
        if (!reset && !(if_stall || hazard_stall)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_capture_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
                cap_t e;
                e = sb_q.pop_front();
                check("cap_pc", if_pc, e.pc);
                check("cap_instr", if_instruction, e.instr);
            end
        end
    end

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = '0;
        hazard_stall = 1'b0; imem_busywait = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // IDLE cycle right after reset
        expect_cap(32'h0, NOP);
        @(negedge clk);
        check("idle_read", {31'b0, imem_read}, 32'd0);
        check("idle_stall", {31'b0, if_stall}, 32'd0);
        check("idle_pc", if_pc, 32'h0);
        next_cycle();

        // zero-latency fetches at 0x0, 0x4
        expect_cap(32'h0, 32'h0050_0093);
        @(negedge clk);
        check("fetch0_read", {31'b0, imem_read}, 32'd1);
        next_cycle();
        expect_cap(32'h4, 32'h0060_0113);
        next_cycle();

        // 3 wait cycles at 0x8
        imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_stall", {31'b0, if_stall}, 32'd1);
            check("wait_addr", imem_addr, 32'h8);
            next_cycle();
        end
        imem_busywait = 1'b0;
        expect_cap(32'h8, 32'h0070_0193);
        next_cycle();
        expect_cap(32'hC, 32'h0080_0213);
        @(negedge clk);
        check("after_wait_addr", imem_addr, 32'hC);
        next_cycle();

        // hazard stall over completion at 0x10
        hazard_stall = 1'b1;
        next_cycle();
        @(negedge clk);
        check("hold_read", {31'b0, imem_read}, 32'd0);
        check("hold_instr", if_instruction, 32'h00A0_0513);
        check("hold_stall", {31'b0, if_stall}, 32'd0);
        next_cycle();
        hazard_stall = 1'b0;
        expect_cap(32'h10, 32'h00A0_0513);
        next_cycle();
        @(negedge clk);
        check("resume_addr", imem_addr, 32'h14);
        check("resume_read", {31'b0, imem_read}, 32'd1);
        for (int a = 32'h14; a < 32'h20; a += 4) begin
            expect_cap(a, {16'hC0DE, 16'(a)});
            next_cycle();
        end

        // redirect to 0x103 while the fetch at 0x20 is still waiting
        imem_busywait = 1'b1; branch_taken = 1'b1; branch_target = 32'h103;
        @(negedge clk);
        check("kill_addr", imem_addr, 32'h20);
        next_cycle();
        branch_taken = 1'b0; branch_target = 32'hDEAD_BEEF;
        @(negedge clk);
        check("kill_hold_read", {31'b0, imem_read}, 32'd1);
        check("kill_hold_addr", imem_addr, 32'h20);
        next_cycle();
        imem_busywait = 1'b0;
        expect_cap(32'h20, NOP);
        next_cycle();
        expect_cap(32'h100, 32'h0200_0693);
        @(negedge clk);
        check("redirect_addr", imem_addr, 32'h100);
        next_cycle();

        // redirect coinciding with completion at 0x104 -> 0x30, then 0x30 -> 0x200
        branch_taken = 1'b1; branch_target = 32'h30;
        expect_cap(32'h104, NOP);
        next_cycle();
        branch_target = 32'h200;
        expect_cap(32'h30, NOP);
        next_cycle();
        branch_taken = 1'b0;
        expect_cap(32'h200, 32'h0400_0793);
        @(negedge clk);
        check("br_complete_addr", imem_addr, 32'h200);
        next_cycle();

        // wrap-around: redirect to 0xFFFFFFFF (aligned to ...FC), then +4 wraps to 0
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        expect_cap(32'h204, NOP);
        next_cycle();
        branch_taken = 1'b0;
        expect_cap(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        @(negedge clk);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'h0);

        // reset in the middle of a wait
        imem_busywait = 1'b1;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_read", {31'b0, imem_read}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_stall", {31'b0, if_stall}, 32'd0);
        check("rst_instr", if_instruction, NOP);
        next_cycle();
        reset = 1'b0; imem_busywait = 1'b0;
        expect_cap(32'h0, NOP);
        next_cycle();
        expect_cap(32'h0, 32'h0050_0093);
        next_cycle();
        @(negedge clk);
        check("restart_addr", imem_addr, 32'h4);
        reset = 1'b1;
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
